pipe_ctrl: RTL and testbench

Pipeline sequencer for the 16-bit five-stage core. It owns the single shared SRAM port, time-multiplexing it between instruction fetch and MEM-stage data access. It issues one-cycle advance pulses to the PC and to the IF/ID, ID/EX, EX/MEM and MEM/WB registers, which are fed to their `mwi_en`-style enable inputs. It also inserts bubbles on load-use hazards and flushes IF/ID on taken branches.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_load_use_detect.sv | 15 +
 rtl/pipe_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline sequencer.
package pipe_ctrl_pkg;

  localparam logic [3:0] REG_INVALID  = 4'hF;
  localparam int         MEM_WAIT_DEF = 2;

  typedef enum logic [1:0] {
    S_ARB   = 2'd0,
    S_DATA  = 2'd1,
    S_FETCH = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Load-use hazard detect: the EX-stage load writes a register the ID-stage instruction reads.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] id_rs_a,
  input  logic [3:0] id_rs_b,
  input  logic [3:0] ex_wreg_addr,
  input  logic       ex_is_load,
  output logic       hz
);

  assign hz = ex_is_load & (ex_wreg_addr != REG_INVALID) &
              ((ex_wreg_addr == id_rs_a) | (ex_wreg_addr == id_rs_b));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates the shared SRAM port per slot and issues
// one-cycle advance pulses with load-use stall and taken-branch flush.
//
// state   | meaning
// S_ARB   | one cycle; sample mem_req/mem_wr, SRAM idle
// S_DATA  | MEM-stage data access, MEM_WAIT cycles
// S_FETCH | instruction fetch, MEM_WAIT cycles; last cycle is the slot end
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEF
) (
  input  logic       mwi_clk,
  input  logic       mwi_rst,
  input  logic [3:0] id_rs_a,
  input  logic [3:0] id_rs_b,
  input  logic [3:0] ex_wreg_addr,
  input  logic       ex_is_load,
  input  logic       mem_req,
  input  logic       mem_wr,
  input  logic       br_taken,
  output logic       mem_sel,
  output logic       mem_cs,
  output logic       mem_we,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_bubble
);

  localparam logic [3:0] LP_LAST = 4'(MEM_WAIT - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_we, w_we_nxt;
  logic       w_last;
  logic       w_hz;
  logic       w_slot_end;

  load_use_detect u_load_use_detect (
    .id_rs_a      (id_rs_a),
    .id_rs_b      (id_rs_b),
    .ex_wreg_addr (ex_wreg_addr),
    .ex_is_load   (ex_is_load),
    .hz           (w_hz)
  );

  assign w_last = (r_cnt == LP_LAST);

  always_ff @(posedge mwi_clk or negedge mwi_rst) begin
    if (!mwi_rst) begin
      r_state <= S_ARB;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = r_we;
    w_slot_end  = 1'b0;
    mem_sel     = 1'b0;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    case (r_state)
      S_ARB: begin
        w_cnt_nxt   = 4'd0;
        w_we_nxt    = mem_req & mem_wr;
        w_state_nxt = mem_req ? S_DATA : S_FETCH;
      end
      S_DATA: begin
        // select held for the whole state so the SRAM address never moves mid-access
        mem_sel = 1'b1;
        mem_cs  = 1'b1;
        mem_we  = r_we;
        if (w_last) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_FETCH;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_FETCH: begin
        mem_cs = 1'b1;
        if (w_last) begin
          w_cnt_nxt   = 4'd0;
          w_slot_end  = 1'b1;
          w_state_nxt = S_ARB;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = S_ARB;
      end
    endcase
  end

  // a hazard holds PC and IF/ID so the same instruction is refetched; branch is ignored that slot
  assign pc_en       = w_slot_end & ~w_hz;
  assign ifid_en     = w_slot_end & ~w_hz;
  assign idex_en     = w_slot_end;
  assign exmem_en    = w_slot_end;
  assign memwb_en    = w_slot_end;
  assign ifid_flush  = w_slot_end & ~w_hz & br_taken;
  assign idex_bubble = w_slot_end & w_hz;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle waveform model per slot, two instances (MEM_WAIT 2 and 1).
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] a_rs_a = '0, a_rs_b = '0, a_wreg = '0;
  logic       a_load = 0, a_req = 0, a_wr = 0, a_br = 0;
  logic       a_sel, a_cs, a_we, a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_flush, a_bubble;
  logic [3:0] b_rs_a = '0, b_rs_b = '0, b_wreg = '0;
  logic       b_load = 0, b_req = 0, b_wr = 0, b_br = 0;
  logic       b_sel, b_cs, b_we, b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_flush, b_bubble;
  logic [9:0] a_out, b_out;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.MEM_WAIT(2)) u_dut_a (
    .mwi_clk(clk), .mwi_rst(rst),
    .id_rs_a(a_rs_a), .id_rs_b(a_rs_b), .ex_wreg_addr(a_wreg), .ex_is_load(a_load),
    .mem_req(a_req), .mem_wr(a_wr), .br_taken(a_br),
    .mem_sel(a_sel), .mem_cs(a_cs), .mem_we(a_we), .pc_en(a_pc), .ifid_en(a_ifid),
    .idex_en(a_idex), .exmem_en(a_exmem), .memwb_en(a_memwb),
    .ifid_flush(a_flush), .idex_bubble(a_bubble)
  );

  pipe_ctrl #(.MEM_WAIT(1)) u_dut_b (
    .mwi_clk(clk), .mwi_rst(rst),
    .id_rs_a(b_rs_a), .id_rs_b(b_rs_b), .ex_wreg_addr(b_wreg), .ex_is_load(b_load),
    .mem_req(b_req), .mem_wr(b_wr), .br_taken(b_br),
    .mem_sel(b_sel), .mem_cs(b_cs), .mem_we(b_we), .pc_en(b_pc), .ifid_en(b_ifid),
    .idex_en(b_idex), .exmem_en(b_exmem), .memwb_en(b_memwb),
    .ifid_flush(b_flush), .idex_bubble(b_bubble)
  );

  // {sel, cs, we, pc, ifid, idex, exmem, memwb, flush, bubble}
  assign a_out = {a_sel, a_cs, a_we, a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_flush, a_bubble};
  assign b_out = {b_sel, b_cs, b_we, b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_flush, b_bubble};

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Called while the DUT sits in its arbitration cycle; returns in the next slot's arbitration cycle.
  task automatic run_slot(input int dut, input int mw, input bit req, input bit wr, input bit load,
                          input logic [3:0] wreg, input logic [3:0] rsa, input logic [3:0] rsb,
                          input bit br, input string tag);
    bit hz;
    int len;
    logic [9:0] exp;
    logic [9:0] got;
    if (dut == 0) begin
      a_req = req; a_wr = wr; a_load = load; a_wreg = wreg; a_rs_a = rsa; a_rs_b = rsb; a_br = br;
    end else begin
      b_req = req; b_wr = wr; b_load = load; b_wreg = wreg; b_rs_a = rsa; b_rs_b = rsb; b_br = br;
    end
    hz  = load && (wreg != 4'hF) && (wreg == rsa || wreg == rsb);
    len = req ? 1 + 2 * mw : 1 + mw;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 0) exp = 10'b0;
      else if (req && k <= mw) exp = {1'b1, 1'b1, wr, 7'b0};
      else begin
        exp = {1'b0, 1'b1, 1'b0, 7'b0};
        if (k == len - 1) begin
          if (hz)      exp[6:0] = 7'b0011101;
          else if (br) exp[6:0] = 7'b1111110;
          else         exp[6:0] = 7'b1111100;
        end
      end
      got = (dut == 0) ? a_out : b_out;
      check($sformatf("%s cyc%0d", tag, k), got, exp);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit         req, wr, load, br;
    logic [3:0] wreg, rsa, rsb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", a_out, 10'b0);
    check("reset_b", b_out, 10'b0);
    @(posedge clk);
    #1 rst = 1'b1;

    run_slot(0, 2, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, "plain1");
    run_slot(0, 2, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, "plain2");
    run_slot(0, 2, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0, "store");
    run_slot(0, 2, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, "load");
    run_slot(0, 2, 0, 0, 1, 4'h3, 4'h0, 4'h3, 0, "loaduse_b");
    run_slot(0, 2, 0, 0, 1, 4'h5, 4'h5, 4'h0, 0, "loaduse_a");
    run_slot(0, 2, 0, 0, 1, 4'hF, 4'hF, 4'hF, 0, "wreg_invalid");
    run_slot(0, 2, 0, 0, 0, 4'h3, 4'h3, 4'h3, 0, "not_load");
    run_slot(0, 2, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, "branch");
    run_slot(0, 2, 1, 1, 1, 4'h3, 4'h0, 4'h3, 1, "branch_hz");
    run_slot(0, 2, 1, 0, 0, 4'h0, 4'h0, 4'h0, 1, "branch_data");

    // reset in the second data cycle of a store slot
    a_req = 1; a_wr = 1; a_load = 0; a_br = 0;
    @(negedge clk);
    check("mid_arb", a_out, 10'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_data0", a_out, 10'b1110000000);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_data1", a_out, 10'b1110000000);
    #2 rst = 1'b0;
    #1 check("mid_reset", a_out, 10'b0);
    @(posedge clk); #1;
    check("mid_reset_hold", a_out, 10'b0);
    rst = 1'b1;
    run_slot(0, 2, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      req  = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      load = 1'($urandom_range(0, 1));
      br   = 1'($urandom_range(0, 1));
      wreg = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      rsa  = 4'($urandom_range(0, 3));
      rsb  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      run_slot(0, 2, req, wr, load, wreg, rsa, rsb, br, $sformatf("rnd_a%0d", i));
    end

    // realign both instances for the MEM_WAIT=1 run
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++)
      run_slot(1, 1, 1'(i % 2 == 0), 1'(i % 4 == 0), 0, 4'h0, 4'h0, 4'h0, 0,
               $sformatf("mw1_alt%0d", i));
    run_slot(1, 1, 0, 0, 1, 4'h2, 4'h2, 4'h9, 1, "mw1_hz");
    run_slot(1, 1, 1, 1, 0, 4'h2, 4'h2, 4'h9, 1, "mw1_br");
    for (int i = 0; i < 30; i++) begin
      req  = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      load = 1'($urandom_range(0, 1));
      br   = 1'($urandom_range(0, 1));
      wreg = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      rsa  = 4'($urandom_range(0, 3));
      rsb  = 4'($urandom_range(0, 15));
      run_slot(1, 1, req, wr, load, wreg, rsa, rsb, br, $sformatf("rnd_b%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
